// File: rtl/uart_frame_packer.sv
// uart_frame_packer: parses 55 AA LEN payload CHK frames from a UART byte stream and packs payload into 16-bit words behind a show-ahead FIFO
module uart_frame_packer #(
  parameter int CLK_FREQ      = 'd50_000_000,
  parameter int UART_BPS      = 'd9600,
  parameter int TIMEOUT_BYTES = 'd4,
  parameter int FIFO_DEPTH    = 'd4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  pi_data,
  input  logic        pi_flag,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic        frame_err,
  output logic [1:0]  err_code
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TO = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS);
  localparam logic [23:0] TO_LAST = 24'(TO - 1);
  typedef enum logic [2:0] {IDLE, HDR2, LEN, PAYLOAD, CHK} state_t;
  state_t st;
  logic [7:0] plen, acc, idx, hold;
  logic [23:0] tcnt;
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [15:0] mem [FIFO_DEPTH];
  logic full, pop, push_req, push, ovf, tmo;
  assign wr_valid = cnt != '0;
  assign wr_data  = mem[rp];
  assign full     = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop      = wr_valid && wr_ready;
  assign push_req = pi_flag && st == PAYLOAD && idx[0];
  // a pop on the same edge frees the slot, so a full FIFO still accepts the word
  assign push     = push_req && (!full || pop);
  assign ovf      = push_req && full && !pop;
  assign tmo      = st != IDLE && !pi_flag && tcnt == TO_LAST;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {hold, pi_data};
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st         <= IDLE;
      plen       <= '0;
      acc        <= '0;
      idx        <= '0;
      hold       <= '0;
      tcnt       <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_len  <= '0;
      err_code   <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      tcnt       <= (st == IDLE || pi_flag || tmo) ? '0 : tcnt + 24'd1;
      if (tmo) begin
        st        <= IDLE;
        frame_err <= 1'b1;
        err_code  <= 2'd3;
      end else if (pi_flag) begin
        case (st)
          IDLE: st <= pi_data == 8'h55 ? HDR2 : IDLE;
          HDR2: st <= pi_data == 8'hAA ? LEN : pi_data == 8'h55 ? HDR2 : IDLE;
          LEN: begin
            // odd check also rejects 255
            if (pi_data[0] || pi_data == 8'd0) begin
              st        <= IDLE;
              frame_err <= 1'b1;
              err_code  <= 2'd1;
            end else begin
              st   <= PAYLOAD;
              plen <= pi_data;
              acc  <= pi_data;
              idx  <= '0;
            end
          end
          PAYLOAD: begin
            acc <= acc + pi_data;
            idx <= idx + 8'd1;
            if (!idx[0]) hold <= pi_data;
            if (ovf) begin
              st        <= IDLE;
              frame_err <= 1'b1;
              err_code  <= 2'd0;
            end else if (idx + 8'd1 == plen) st <= CHK;
          end
          CHK: begin
            st <= IDLE;
            if (pi_data == acc) begin
              frame_done <= 1'b1;
              frame_len  <= plen;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_packer.sv
// tb_uart_frame_packer: byte-vector table plus hand sequences for overflow, timeout and reset
module tb_uart_frame_packer;
  logic        sys_clk = 1'b0, sys_rst = 1'b1, pi_flag = 1'b0, wr_ready = 1'b1;
  logic [7:0]  pi_data = '0;
  logic [15:0] wr_data;
  logic        wr_valid, frame_done, frame_err;
  logic [7:0]  frame_len;
  logic [1:0]  err_code;
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];
  typedef struct {
    logic [7:0] b;
    logic       done;
    logic       err;
    logic [1:0] code;
    logic [7:0] flen;
  } vec_t;
  vec_t v[32];

  uart_frame_packer #(.CLK_FREQ(1000), .UART_BPS(100), .TIMEOUT_BYTES(4), .FIFO_DEPTH(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge sys_clk);
    pi_data = b;
    pi_flag = 1'b1;
    @(negedge sys_clk);
    pi_flag = 1'b0;
  endtask

  // every accepted word is compared against the expected queue
  always @(negedge sys_clk) begin
    #1;
    if (!sys_rst && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL word_extra: got %h expected no word", wr_data);
      end else chk("word", wr_data, exp_q.pop_front());
    end
  end

  initial begin
    int hit, pulses;
    v = '{
      '{8'h55,0,0,0,0}, '{8'hAA,0,0,0,0}, '{8'h04,0,0,0,0}, '{8'h12,0,0,0,0},
      '{8'h34,0,0,0,0}, '{8'h56,0,0,0,0}, '{8'h78,0,0,0,0}, '{8'h18,1,0,0,4},
      '{8'h55,0,0,0,4}, '{8'hAA,0,0,0,4}, '{8'h02,0,0,0,4}, '{8'hAB,0,0,0,4},
      '{8'hCD,0,0,0,4}, '{8'h00,0,1,2,4},
      '{8'h55,0,0,0,4}, '{8'h55,0,0,0,4}, '{8'hAA,0,0,0,4}, '{8'h03,0,1,1,4},
      '{8'h55,0,0,0,4}, '{8'h12,0,0,0,4},
      '{8'h55,0,0,0,4}, '{8'hAA,0,0,0,4}, '{8'h02,0,0,0,4}, '{8'h11,0,0,0,4},
      '{8'h22,0,0,0,4}, '{8'h35,1,0,0,2},
      '{8'h55,0,0,0,2}, '{8'hAA,0,0,0,2}, '{8'h00,0,1,1,2},
      '{8'h55,0,0,0,2}, '{8'hAA,0,0,0,2}, '{8'hFF,0,1,1,2}
    };
    repeat (3) @(negedge sys_clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_err_code", err_code, 0);
    sys_rst = 1'b0;
    exp_q = '{16'h1234, 16'h5678, 16'hABCD, 16'h1122};
    foreach (v[i]) begin
      send(v[i].b);
      chk($sformatf("done[%0d]", i), frame_done, v[i].done);
      chk($sformatf("err[%0d]", i), frame_err, v[i].err);
      if (v[i].err) chk($sformatf("code[%0d]", i), err_code, v[i].code);
      chk($sformatf("len[%0d]", i), frame_len, v[i].flen);
    end
    repeat (4) @(negedge sys_clk);
    chk("table_words_left", exp_q.size(), 0);

    wr_ready = 1'b0;
    send(8'h55); send(8'hAA); send(8'h0A); send(8'h01); send(8'h02);
    chk("push_latency_valid", wr_valid, 1);
    chk("push_latency_data", wr_data, 16'h0102);
    for (int b = 3; b <= 8; b++) send(8'(b));
    chk("full_no_err", frame_err, 0);
    send(8'h09); send(8'h0A);
    chk("ovf_err", frame_err, 1);
    chk("ovf_code", err_code, 0);
    chk("ovf_done", frame_done, 0);
    exp_q = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
    @(negedge sys_clk);
    wr_ready = 1'b1;
    repeat (8) @(negedge sys_clk);
    chk("ovf_words_left", exp_q.size(), 0);
    chk("ovf_drained_valid", wr_valid, 0);

    send(8'h55); send(8'hAA); send(8'h04); send(8'h12);
    hit = -1;
    pulses = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge sys_clk);
      if (frame_err) begin
        pulses++;
        if (hit < 0) hit = i;
      end
    end
    chk("tmo_pulses", pulses, 1);
    chk("tmo_cycle", hit, 400);
    chk("tmo_code", err_code, 3);

    wr_ready = 1'b0;
    send(8'h55); send(8'hAA); send(8'h04); send(8'h12); send(8'h34);
    chk("pre_rst_valid", wr_valid, 1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_wr_valid", wr_valid, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    chk("mid_rst_frame_len", frame_len, 0);
    chk("mid_rst_err_code", err_code, 0);
    sys_rst = 1'b0;
    wr_ready = 1'b1;
    exp_q = '{16'h1122};
    send(8'h55); send(8'hAA); send(8'h02); send(8'h11); send(8'h22); send(8'h35);
    chk("post_rst_done", frame_done, 1);
    chk("post_rst_len", frame_len, 2);
    repeat (4) @(negedge sys_clk);
    chk("post_rst_words_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
